// File: rtl/fifo_ser_pkg.sv
// Shared types and defaults for the FIFO drain serializer.
// Frame state encoding and default geometry live here.
package fifo_ser_pkg;

    localparam int DEF_DWIDTH       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } ser_state_t;

endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO read port as seen by its single reader.
// master = the serializer (owns read_o), slave = the FIFO.
interface fifo_serializer_if
    import fifo_ser_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
);
    logic              empty_i;
    logic [DWIDTH-1:0] data_i;
    logic              read_o;

    modport master (
        input  empty_i,
        input  data_i,
        output read_o
    );

    modport slave (
        output empty_i,
        output data_i,
        input  read_o
    );
endinterface

// File: rtl/fifo_serializer_bit_timer.sv
// Per-bit cycle counter for the serializer.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_timer
    import fifo_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Wrapping on tick keeps bit boundaries aligned without a state-change compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/fifo_serializer.sv
// Drains the byte FIFO onto an async serial line:
// start, DWIDTH data bits LSB-first, optional even parity, stop.
module fifo_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_serializer_if.master       fifo,
    output logic                    tx_o,
    output logic                    busy_o,
    output logic                    frame_done_o
);
    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

    ser_state_t        state;
    ser_state_t        state_n;
    logic [DWIDTH-1:0] sh;
    logic [DWIDTH-1:0] sh_n;
    logic [BW-1:0]     bidx;
    logic [BW-1:0]     bidx_n;
    logic              par;
    logic              par_n;
    logic              tx_n;
    logic              tick;
    logic              clr;

    assign fifo.read_o = (state == IDLE) && !fifo.empty_i;

    // Timer is held at zero between frames so START gets a full bit.
    assign clr = (state == IDLE) || (state == DONE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        sh_n    = sh;
        bidx_n  = bidx;
        par_n   = par;
        unique case (state)
            IDLE: begin
                if (fifo.read_o) begin
                    sh_n    = fifo.data_i;
                    par_n   = ^fifo.data_i;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bidx_n  = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    sh_n = sh >> 1;
                    if (bidx == LAST_BIT) begin
                        bidx_n  = '0;
                        state_n = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bidx_n = bidx + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line level is precomputed from the next state so tx_o is a clean flop.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sh           <= '0;
            bidx         <= '0;
            par          <= 1'b0;
            tx_o         <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_n;
            sh           <= sh_n;
            bidx         <= bidx_n;
            par          <= par_n;
            tx_o         <= tx_n;
            busy_o       <= (state_n inside {START, DATA, PARITY, STOP});
            frame_done_o <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench: two serializers (parity on / off) fed by FIFO
// models; a negedge monitor checks every frame cycle by cycle.
module tb_fifo_serializer;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    function automatic void chk(input int g, input string nm,
                                input logic [63:0] got,
                                input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL u%0d.%s got=%0h exp=%0h t=%0t",
                     g, nm, got, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam bit PE   = (g == 0);
        localparam int NB   = 1 + DW + (PE ? 1 : 0) + 1;
        localparam int FLEN = NB * CPB + 1;

        logic        rst_n;
        logic        tx;
        logic        busy;
        logic        done;
        logic        flick;
        logic        flick_en;
        logic        pop_seen;
        logic [7:0]  fq[$];
        logic [7:0]  exq[$];
        int          pt[$];
        bit          fin;
        bit          active;
        int          cyc;
        int          t;
        int          k;
        int          errs;
        int          idle_errs;
        logic [7:0]  eb;
        logic [15:0] ebits;
        logic [15:0] abits;

        fifo_serializer_if #(.DWIDTH(DW)) bus ();

        fifo_serializer #(
            .DWIDTH      (DW),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .fifo        (bus),
            .tx_o        (tx),
            .busy_o      (busy),
            .frame_done_o(done)
        );

        // Reference frame: start 0, data LSB-first, even parity, stop 1.
        function automatic logic [15:0] frame_of(input logic [7:0] b);
            logic [15:0] f;
            f    = '1;
            f[0] = 1'b0;
            for (int j = 0; j < 8; j++) f[1 + j] = b[j];
            if (PE) f[9] = ($countones(b) % 2) == 1;
            return f;
        endfunction

        // FIFO model: pops after the edge that consumed the head byte.
        always @(posedge clk) begin
            #1;
            if (pop_seen) begin
                pop_seen = 1'b0;
                if (fq.size() > 0) void'(fq.pop_front());
            end
            flick       = flick_en ? ~flick : 1'b0;
            bus.empty_i = (fq.size() == 0) || flick;
            if (bus.empty_i) bus.data_i = 8'($urandom);
            else             bus.data_i = fq[0];
        end

        always @(negedge clk) begin
            cyc++;
            if (!rst_n) begin
                active = 1'b0;
            end else if (bus.read_o) begin
                chk(g, "pop_legal", {62'd0, active, bus.empty_i}, 64'd0);
                pt.push_back(cyc);
                pop_seen = 1'b1;
                if (exq.size() == 0) begin
                    chk(g, "pop_unexp", 64'd1, 64'd0);
                    ebits = '1;
                end else begin
                    eb    = exq.pop_front();
                    ebits = frame_of(eb);
                end
                active = 1'b1;
                t      = 0;
                errs   = 0;
                abits  = '1;
            end else if (active) begin
                t++;
                if (t <= NB * CPB) begin
                    k = (t - 1) / CPB;
                    if (tx !== ebits[k] || busy !== 1'b1 || done !== 1'b0)
                        errs++;
                    if ((t - 1) % CPB == CPB / 2) abits[k] = tx;
                end else begin
                    chk(g, "done_pulse", {61'd0, tx, busy, done}, 64'd5);
                    chk(g, "frame_bits", {48'd0, abits}, {48'd0, ebits});
                    chk(g, "frame_wave", errs, 0);
                    active = 1'b0;
                end
            end else if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                idle_errs++;
            end
        end

        task automatic push(input logic [7:0] b);
            fq.push_back(b);
            exq.push_back(b);
        endtask

        task automatic settle(input string nm);
            int n;
            n = 0;
            while ((fq.size() != 0 || exq.size() != 0 || active) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk(g, nm, {63'd0, n < 5000}, 64'd1);
            repeat (3) @(negedge clk);
        endtask

        initial begin
            logic [7:0] seq[3];
            int         n;
            seq         = '{8'h01, 8'h02, 8'hFD};
            rst_n       = 1'b0;
            flick       = 1'b0;
            flick_en    = 1'b0;
            pop_seen    = 1'b0;
            bus.empty_i = 1'b1;
            bus.data_i  = '0;
            repeat (3) @(negedge clk);
            chk(g, "rst_vals", {60'd0, tx, busy, done, bus.read_o}, 64'h8);
            #2 rst_n = 1'b1;

            repeat (500) @(negedge clk);
            chk(g, "idle_pops", pt.size(), 0);
            chk(g, "idle_line", idle_errs, 0);

            pt.delete();
            push(PE ? 8'hA5 : 8'hFF);
            settle("single_end");
            chk(g, "single_pops", pt.size(), 1);

            pt.delete();
            foreach (seq[i]) push(seq[i]);
            settle("b2b_end");
            chk(g, "b2b_pops", pt.size(), 3);
            for (int i = 1; i < 3 && i < pt.size(); i++)
                chk(g, "b2b_gap", pt[i] - pt[i - 1], FLEN + 1);

            pt.delete();
            flick_en = 1'b1;
            for (int i = 0; i < 10; i++) begin
                push(8'($urandom));
                repeat ($urandom_range(0, 60)) @(negedge clk);
            end
            settle("flick_end");
            flick_en = 1'b0;
            chk(g, "flick_pops", pt.size(), 10);

            pt.delete();
            push(8'h96);
            n = 0;
            while (!(active && t == 4 * CPB + 2) && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk(g, "rst_reach", {63'd0, n < 500}, 64'd1);
            #2 rst_n = 1'b0;
            #1 chk(g, "rst_async", {61'd0, tx, busy, done}, 64'd4);
            repeat (3) @(negedge clk);
            chk(g, "rst_hold", {60'd0, tx, busy, done, bus.read_o}, 64'h8);
            #2 rst_n = 1'b1;
            repeat (5) @(negedge clk);
            pt.delete();
            push(8'h3C);
            settle("rst_fresh_end");
            chk(g, "rst_fresh_pops", pt.size(), 1);

            chk(g, "idle_line_end", idle_errs, 0);
            fin = 1'b1;
        end
    end

    initial begin
        wait (u[0].fin && u[1].fin);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog tests=%0d fails=%0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
